// File: rtl/otp_auth_if.sv
// Signal bundle between the front-panel synchronisers, the OTP authenticator and the display mux.
interface otp_auth_if #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 3
);
  localparam int OTP_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               gen_req;
  logic [OTP_W-1:0]   otp_digits;
  logic               otp_valid;
  logic [OTP_W-1:0]   entry_digits;
  logic [IDX_W-1:0]   digit_idx;
  logic [TRY_W-1:0]   tries;
  logic               auth_ok;
  logic               auth_fail;
  logic               fail_timeout;
  logic               locked;

  modport master (
    output digit_in, digit_valid, gen_req,
    input  otp_digits, otp_valid, entry_digits, digit_idx, tries,
           auth_ok, auth_fail, fail_timeout, locked
  );

  modport slave (
    input  digit_in, digit_valid, gen_req,
    output otp_digits, otp_valid, entry_digits, digit_idx, tries,
           auth_ok, auth_fail, fail_timeout, locked
  );
endinterface

// File: rtl/otp_auth_engine.sv
// One-time-password authenticator: LFSR-issued code, digit-by-digit entry, retry lockout and OTP lifetime.
module otp_auth_engine #(
  parameter int                DIGIT_W     = 4,
  parameter int                NUM_DIGITS  = 4,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter int                MAX_TRIES   = 3,
  parameter int                TIMEOUT_CYC = 1000000,
  parameter int                LOCK_CYC    = 5000000
) (
  input  logic      clk,
  input  logic      reset,
  otp_auth_if.slave bus
);
  localparam int OTP_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  if (OTP_W > LFSR_W) begin : g_bad_width
    $error("otp_auth_engine: NUM_DIGITS*DIGIT_W exceeds LFSR_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [OTP_W-1:0]   otp_q, otp_d;
  logic [OTP_W-1:0]   entry_q, entry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               otp_valid_q, otp_valid_d;
  logic               locked_q, locked_d;
  logic               auth_ok_q, auth_ok_d;
  logic               auth_fail_q, auth_fail_d;
  logic               fail_timeout_q, fail_timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED_EFF;
      otp_q          <= '0;
      entry_q        <= '0;
      idx_q          <= '0;
      tries_q        <= '0;
      timer_q        <= '0;
      lock_cnt_q     <= '0;
      otp_valid_q    <= 1'b0;
      locked_q       <= 1'b0;
      auth_ok_q      <= 1'b0;
      auth_fail_q    <= 1'b0;
      fail_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      otp_q          <= otp_d;
      entry_q        <= entry_d;
      idx_q          <= idx_d;
      tries_q        <= tries_d;
      timer_q        <= timer_d;
      lock_cnt_q     <= lock_cnt_d;
      otp_valid_q    <= otp_valid_d;
      locked_q       <= locked_d;
      auth_ok_q      <= auth_ok_d;
      auth_fail_q    <= auth_fail_d;
      fail_timeout_q <= fail_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    otp_d          = otp_q;
    entry_d        = entry_q;
    idx_d          = idx_q;
    tries_d        = tries_q;
    timer_d        = timer_q;
    lock_cnt_d     = lock_cnt_q;
    auth_ok_d      = 1'b0;
    auth_fail_d    = 1'b0;
    fail_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.gen_req) begin
          otp_d   = lfsr_q[OTP_W-1:0];
          entry_d = '0;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_ARMED;
        end
      end

      // Timeout outranks a fresh request, which in turn outranks a digit on the same edge.
      S_ARMED: begin
        if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          auth_fail_d    = 1'b1;
          fail_timeout_d = 1'b1;
          otp_d          = '0;
          entry_d        = '0;
          idx_d          = '0;
          timer_d        = '0;
          state_d        = S_IDLE;
        end else if (bus.gen_req) begin
          otp_d   = lfsr_q[OTP_W-1:0];
          entry_d = '0;
          idx_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (bus.digit_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                entry_d[i*DIGIT_W +: DIGIT_W] = bus.digit_in;
              end
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              state_d = S_CHECK;
            end
          end
        end
      end

      // The lifetime keeps running through a retry, so it saturates here and expires back in ARMED.
      S_CHECK: begin
        if (timer_q != TMR_W'(TIMEOUT_CYC - 1)) begin
          timer_d = timer_q + TMR_W'(1);
        end
        entry_d = '0;
        idx_d   = '0;
        if (entry_q == otp_q) begin
          auth_ok_d = 1'b1;
          tries_d   = '0;
          otp_d     = '0;
          state_d   = S_IDLE;
        end else begin
          auth_fail_d = 1'b1;
          tries_d     = tries_q + TRY_W'(1);
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            otp_d      = '0;
            lock_cnt_d = '0;
            state_d    = S_LOCKED;
          end else begin
            state_d = S_ARMED;
          end
        end
      end

      S_LOCKED: begin
        if (lock_cnt_q == LCK_W'(LOCK_CYC - 1)) begin
          lock_cnt_d = '0;
          tries_d    = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    otp_valid_d = (state_d == S_ARMED) || (state_d == S_CHECK);
    locked_d    = (state_d == S_LOCKED);
  end

  assign bus.otp_digits   = otp_q;
  assign bus.otp_valid    = otp_valid_q;
  assign bus.entry_digits = entry_q;
  assign bus.digit_idx    = idx_q;
  assign bus.tries        = tries_q;
  assign bus.auth_ok      = auth_ok_q;
  assign bus.auth_fail    = auth_fail_q;
  assign bus.fail_timeout = fail_timeout_q;
  assign bus.locked       = locked_q;
endmodule

// File: tb/tb_otp_auth_engine.sv
// Randomised self-checking bench for otp_auth_engine against a behavioural model of the authenticator rules.
module tb_otp_auth_engine;
  localparam int          DW   = 4;
  localparam int          ND   = 4;
  localparam int          MT   = 3;
  localparam int          TO   = 32;
  localparam int          LC   = 16;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  otp_auth_if #(.DIGIT_W(DW), .NUM_DIGITS(ND), .MAX_TRIES(MT)) bus ();

  otp_auth_engine #(
    .DIGIT_W(DW), .NUM_DIGITS(ND), .LFSR_W(16), .LFSR_TAPS(TAPS), .LFSR_SEED(SEED),
    .MAX_TRIES(MT), .TIMEOUT_CYC(TO), .LOCK_CYC(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: the code generator value, the live OTP and the failed-attempt count.
  logic [15:0] m_lfsr  = SEED;
  logic [15:0] m_otp   = 16'h0;
  int          m_tries = 0;

  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ TAPS;
    return n;
  endfunction

  always @(posedge clk) m_lfsr <= reset ? SEED : lfsrNext(m_lfsr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic gen, input logic dv, input logic [3:0] d);
    bus.gen_req     = gen;
    bus.digit_valid = dv;
    bus.digit_in    = d;
    @(posedge clk);
    #1;
    bus.gen_req     = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'h0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_otp"},   32'(bus.otp_digits),   0);
    checkOutput({tag, "_valid"}, 32'(bus.otp_valid),    0);
    checkOutput({tag, "_entry"}, 32'(bus.entry_digits), 0);
    checkOutput({tag, "_idx"},   32'(bus.digit_idx),    0);
    checkOutput({tag, "_tries"}, 32'(bus.tries),        0);
    checkOutput({tag, "_ok"},    32'(bus.auth_ok),      0);
    checkOutput({tag, "_fail"},  32'(bus.auth_fail),    0);
    checkOutput({tag, "_tmo"},   32'(bus.fail_timeout), 0);
    checkOutput({tag, "_lock"},  32'(bus.locked),       0);
  endtask

  task automatic issueOtp(input string tag);
    logic [15:0] expOtp;
    expOtp = m_lfsr;
    applyStimulus(1'b1, 1'b0, 4'h0);
    m_otp = expOtp;
    checkOutput({tag, "_otp"},   32'(bus.otp_digits),   32'(expOtp));
    checkOutput({tag, "_valid"}, 32'(bus.otp_valid),    1);
    checkOutput({tag, "_idx"},   32'(bus.digit_idx),    0);
    checkOutput({tag, "_entry"}, 32'(bus.entry_digits), 0);
    checkOutput({tag, "_tries"}, 32'(bus.tries),        32'(m_tries));
  endtask

  // Holds inputs busy with random requests for the whole lockout, then expects release.
  task automatic waitLock();
    for (int k = 1; k < LC; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      checkOutput("lock_held",  32'(bus.locked),    1);
      checkOutput("lock_noOtp", 32'(bus.otp_valid), 0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0);
    m_tries = 0;
    checkOutput("lock_release", 32'(bus.locked),    0);
    checkOutput("lock_tries0",  32'(bus.tries),     0);
    checkOutput("lock_idle",    32'(bus.otp_valid), 0);
  endtask

  task automatic runAttempt(input logic [15:0] code);
    for (int i = 0; i < ND; i++) begin
      repeat ($urandom_range(0, 1)) applyStimulus(1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b1, code[i*4 +: 4]);
      if (i < ND - 1) checkOutput("entry_idx", 32'(bus.digit_idx), 32'(i + 1));
    end
    checkOutput("entry_full", 32'(bus.entry_digits), 32'(code));
    checkOutput("no_early_verdict", 32'(bus.auth_ok | bus.auth_fail), 0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    if (code == m_otp) begin
      m_tries = 0;
      checkOutput("auth_ok",      32'(bus.auth_ok),    1);
      checkOutput("ok_no_fail",   32'(bus.auth_fail),  0);
      checkOutput("ok_tries",     32'(bus.tries),      0);
      checkOutput("ok_otp_gone",  32'(bus.otp_valid),  0);
      checkOutput("ok_otp_zero",  32'(bus.otp_digits), 0);
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("ok_one_cycle", 32'(bus.auth_ok),    0);
    end else begin
      m_tries++;
      checkOutput("auth_fail",   32'(bus.auth_fail),    1);
      checkOutput("fail_cause",  32'(bus.fail_timeout), 0);
      checkOutput("fail_no_ok",  32'(bus.auth_ok),      0);
      checkOutput("fail_tries",  32'(bus.tries),        32'(m_tries));
      if (m_tries == MT) begin
        checkOutput("lock_enter",  32'(bus.locked),     1);
        checkOutput("lock_otp0",   32'(bus.otp_digits), 0);
        checkOutput("lock_valid0", 32'(bus.otp_valid),  0);
        waitLock();
      end else begin
        checkOutput("retry_otp",   32'(bus.otp_digits), 32'(m_otp));
        checkOutput("retry_valid", 32'(bus.otp_valid),  1);
        checkOutput("retry_idx",   32'(bus.digit_idx),  0);
        checkOutput("retry_lock",  32'(bus.locked),     0);
      end
    end
  endtask

  function automatic logic [15:0] wrongCode(input logic [15:0] otp);
    logic [15:0] c;
    c = 16'($urandom);
    if (c == otp) c = c ^ 16'h0001;
    return c;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] expB;
    bus.gen_req     = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'h0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Correct entry of a freshly issued code.
    repeat ($urandom_range(0, 5)) applyStimulus(1'b0, 1'b0, 4'h0);
    issueOtp("gen1");
    runAttempt(m_otp);

    // Three all-zero entries lead into lockout.
    issueOtp("gen2");
    for (int a = 0; a < MT; a++) runAttempt(16'h0000);

    // One miss, a re-issue that keeps the count, then the code expires untouched.
    issueOtp("gen3");
    runAttempt(wrongCode(m_otp));
    issueOtp("regen3");
    for (int k = 1; k < TO; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("tmo_wait", 32'(bus.auth_fail), 0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("tmo_fail",  32'(bus.auth_fail),    1);
    checkOutput("tmo_flag",  32'(bus.fail_timeout), 1);
    checkOutput("tmo_valid", 32'(bus.otp_valid),    0);
    checkOutput("tmo_otp",   32'(bus.otp_digits),   0);
    checkOutput("tmo_tries", 32'(bus.tries),        32'(m_tries));
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("tmo_pulse", 32'(bus.auth_fail | bus.fail_timeout), 0);

    // A re-issue colliding with a digit drops the digit, then miss and recover on the new code.
    issueOtp("gen4");
    applyStimulus(1'b0, 1'b1, m_otp[3:0]);
    applyStimulus(1'b0, 1'b1, m_otp[7:4]);
    checkOutput("pre_collide_idx", 32'(bus.digit_idx), 2);
    expB = m_lfsr;
    applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    m_otp = expB;
    checkOutput("collide_otp",   32'(bus.otp_digits),   32'(expB));
    checkOutput("collide_idx",   32'(bus.digit_idx),    0);
    checkOutput("collide_entry", 32'(bus.entry_digits), 0);
    runAttempt(wrongCode(m_otp));
    runAttempt(m_otp);

    // Random mix of right and wrong entries tracked by the model.
    for (int r = 0; r < 10; r++) begin
      issueOtp("rand_gen");
      if ($urandom_range(0, 1) == 1) runAttempt(m_otp);
      else runAttempt(wrongCode(m_otp));
    end

    // Reset mid-entry, then a stray digit in IDLE.
    if (bus.locked) waitLock();
    issueOtp("gen5");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'h5);
    checkAllZero("midreset");
    reset   = 1'b0;
    m_tries = 0;
    applyStimulus(1'b0, 1'b1, 4'h7);
    checkOutput("idle_digit_idx",   32'(bus.digit_idx),    0);
    checkOutput("idle_digit_entry", 32'(bus.entry_digits), 0);
    checkOutput("idle_digit_valid", 32'(bus.otp_valid),    0);
    issueOtp("gen6");
    runAttempt(m_otp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
